// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath widths, the NOP encoding and the PC step.
package cpu_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH  = 64;
  localparam int unsigned DEFAULT_INSTR_WIDTH = 32;
  localparam int unsigned PC_INCREMENT        = 4;

  localparam logic [31:0] NOP = 32'hD503201F;

endpackage

// File: rtl/adder.sv
// Shared unsigned adder; the sum wraps modulo 2^IN_LENGTH with no carry out.
module adder #(
  parameter int unsigned IN_LENGTH = 64
) (
  input  logic [IN_LENGTH-1:0] a,
  input  logic [IN_LENGTH-1:0] b,
  output logic [IN_LENGTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, PC+4 via the shared adder, IF/ID pipeline register and a fetch counter.
module instruction_fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned               ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned               INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]     RESET_PC    = '0,
  parameter int unsigned               COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [ADDR_WIDTH-1:0]  if_id_pc,
  output logic [ADDR_WIDTH-1:0]  if_id_pc_plus4,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic                   if_id_valid,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(NOP);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus4_c;
  logic [ADDR_WIDTH-1:0] target_aligned_c;
  logic                  advance_c;
  logic                  unused_target_lsbs;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign target_aligned_c   = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
  assign unused_target_lsbs = ^redirect_target[1:0];
  assign advance_c          = !redirect && !stall;
  assign imem_addr          = pc;

  adder #(.IN_LENGTH(ADDR_WIDTH)) pc_incr (
    .a   (pc),
    .b   (ADDR_WIDTH'(PC_INCREMENT)),
    .sum (pc_plus4_c)
  );

  // Program counter: redirect wins over stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target_aligned_c;
    end else if (!stall) begin
      pc <= pc_plus4_c;
    end
  end

  // IF/ID register: a redirect squashes the slot to a NOP bubble but keeps the old PC fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
      if_id_instr    <= NOP_WORD;
      if_id_valid    <= 1'b0;
    end else if (redirect) begin
      if_id_instr    <= NOP_WORD;
      if_id_valid    <= 1'b0;
    end else if (!stall) begin
      if_id_pc       <= pc;
      if_id_pc_plus4 <= pc_plus4_c;
      if_id_instr    <= imem_instr;
      if_id_valid    <= 1'b1;
    end
  end

  // Counts instructions that entered IF/ID as valid; wraps silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (advance_c) begin
      fetch_count <= fetch_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus random stall/redirect/reset vs a PC model.
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP_W = 32'hD503201F;
  localparam logic [31:0] FIXED = 32'h8B020020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_target = '0;
  logic [31:0] imem_instr;
  logic [63:0] imem_addr;
  logic [63:0] if_id_pc;
  logic [63:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  logic        fixed_mode = 1'b1;
  int          n_checks = 0;
  int          n_fail = 0;

  // Reference state
  logic [63:0] m_pc, m_ifpc, m_ifpc4;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid;

  instruction_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_instr      (imem_instr),
    .imem_addr       (imem_addr),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_instr     (if_id_instr),
    .if_id_valid     (if_id_valid),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] addr, input logic fixed);
    if (fixed) return FIXED;
    return (addr[33:2] * 32'h9E3779B1) ^ addr[63:32];
  endfunction

  always_comb imem_instr = mem_word(imem_addr, fixed_mode);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_ifpc = '0; m_ifpc4 = '0; m_instr = NOP_W; m_valid = 1'b0; m_cnt = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".imem_addr"}, imem_addr, m_pc);
    check({tag, ".if_id_pc"}, if_id_pc, m_ifpc);
    check({tag, ".if_id_pc_plus4"}, if_id_pc_plus4, m_ifpc4);
    check({tag, ".if_id_instr"}, 64'(if_id_instr), 64'(m_instr));
    check({tag, ".if_id_valid"}, 64'(if_id_valid), 64'(m_valid));
    check({tag, ".fetch_count"}, 64'(fetch_count), 64'(m_cnt));
  endtask

  // One clock edge with current inputs; model follows the redirect > stall > normal rules.
  task automatic step(input string tag);
    logic [31:0] fetched;
    fetched = mem_word(m_pc, fixed_mode);
    @(posedge clk);
    #1;
    if (redirect) begin
      m_pc = redirect_target & ~64'h3;
      m_valid = 1'b0;
      m_instr = NOP_W;
    end else if (!stall) begin
      m_ifpc = m_pc;
      m_ifpc4 = m_pc + 64'd4;
      m_instr = fetched;
      m_valid = 1'b1;
      m_cnt = m_cnt + 32'd1;
      m_pc = m_pc + 64'd4;
    end
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Straight-line fetch with constant instruction word
    step("t1.e1");
    check("t1.pc0", if_id_pc, 64'h0);
    check("t1.pc4", if_id_pc_plus4, 64'h4);
    check("t1.instr", 64'(if_id_instr), 64'(FIXED));
    check("t1.cnt", 64'(fetch_count), 64'd1);
    check("t1.addr4", imem_addr, 64'h4);
    step("t1.e2");
    check("t1.addr8", imem_addr, 64'h8);

    // Stall three cycles at pc=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("t2.stall");
      check("t2.addr", imem_addr, 64'h8);
      check("t2.cnt", 64'(fetch_count), 64'd2);
    end
    stall = 1'b0;
    step("t2.resume");
    check("t2.addr12", imem_addr, 64'hC);

    // Redirect at pc=12
    redirect = 1'b1; redirect_target = 64'h100;
    step("t3.redir");
    check("t3.addr", imem_addr, 64'h100);
    check("t3.valid", 64'(if_id_valid), 64'd0);
    check("t3.nop", 64'(if_id_instr), 64'(NOP_W));
    redirect = 1'b0;
    step("t3.next");
    check("t3.ifpc", if_id_pc, 64'h100);
    check("t3.valid1", 64'(if_id_valid), 64'd1);

    // Redirect overrides stall, low bits dropped
    redirect = 1'b1; stall = 1'b1; redirect_target = 64'h203;
    step("t4.redir");
    check("t4.addr", imem_addr, 64'h200);
    check("t4.valid", 64'(if_id_valid), 64'd0);
    redirect = 1'b0; stall = 1'b0;

    // Wrap at top of address space
    redirect = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step("t5.redir");
    redirect = 1'b0;
    step("t5.wrap");
    check("t5.pc4", if_id_pc_plus4, 64'h0);
    check("t5.addr", imem_addr, 64'h0);

    // Random stall/redirect with occasional mid-cycle reset
    fixed_mode = 1'b0;
    for (int c = 0; c < 2048; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else
        redirect_target = {$urandom, $urandom};
      step("rand");
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        #1 reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
